saturn_jump_unit: RTL
=====================

Name: saturn_jump_unit

Overview:
- Downstream consumer of the instruction decoder for all `INSTR_TYPE_JUMP instructions (GOTO, GOSUB, GOVLNG, GOSBVL and future short jumps).
- Collects the offset/address nibbles from the fetch stream, computes the 20-bit target, and issues one-shot PC-load and return-stack-push requests to the PC/RSTK logic.
- Uses the same phase-sequenced nibble stream as the decoder.

Parameters:
- REL_PREFIX, 1, opcode length in nibbles for relative jumps (length < 4); used for the offset base and the return address.
- ABS_PREFIX, 2, opcode length in nibbles for absolute jumps (length == 4); used for the return address.

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  synchronous, active-high reset.
- i_clk_en  in  1  global clock enable; all state and outputs update only when high.
- i_phases  in  4  one-hot nibble-cycle phase.
- i_bus_busy  in  1  bus owns the cycle; no nibble capture while high.
- i_nibble  in  4  current fetched nibble.
- i_instr_type  in  4  decoder instruction type.
- i_instr_execute  in  1  decoder execute strobe.
- i_jump_length  in  3  number of operand nibbles minus 1.
- i_push_pc  in  1  push return address when set.
- i_instr_pc  in  20  address of the instruction's first opcode nibble.
- o_load_pc  out  1  one-enabled-cycle pulse: load o_new_pc into PC.
- o_new_pc  out  20  jump target.
- o_push_en  out  1  one-enabled-cycle pulse, coincident with o_load_pc: push o_push_addr.
- o_push_addr  out  20  return address.
- o_jump_busy  out  1  high in every state except IDLE.
- o_jump_done  out  1  pulse, same cycle as o_load_pc.
- o_error  out  1  sticky illegal-length flag.

Behaviour:
- All outputs are 0 after reset. Reset in any state returns to IDLE and clears the accumulator, counter and o_error.
- Pulses are registered and last exactly one i_clk_en-qualified cycle.
- States: IDLE, COLLECT, COMPUTE, RELEASE.
- IDLE -> COLLECT when i_instr_execute && i_instr_type==`INSTR_TYPE_JUMP && length in 1..4.
  - On entry: latch len, push, instr_pc; cnt=0; acc=0.
  - Length 0 or >4: set o_error and stay in IDLE.
- COLLECT:
  - On i_phases[2] && !i_bus_busy: acc[4*cnt +: 4] <= i_nibble (LSN first); cnt++.
  - When the captured nibble is the one with cnt==len, go to COMPUTE.
  - i_bus_busy freezes capture and cnt.
  - A new execute strobe is ignored while in COLLECT.
- COMPUTE (next enabled cycle):
  - len==4: absolute target, o_new_pc = acc[19:0].
  - len<4: relative target, o_new_pc = instr_pc + REL_PREFIX + sign_extend(acc[4*(len+1)-1:0]), modulo 2^20 (wraps).
  - Assert o_load_pc and o_jump_done.
  - If push: o_push_en=1 and o_push_addr = instr_pc + prefix + len + 1 (mod 2^20).
  - Go to RELEASE.
- RELEASE: wait for i_instr_execute==0, then go to IDLE. This prevents a re-trigger from a stale strobe.
- Latency: o_load_pc is asserted one enabled cycle after the last operand nibble is captured.

Optional Feature:
- Macro: SATURN_JUMP_TRACE_EN.
- When defined:
  - Adds output ports o_dbg_jump_src (20) and o_dbg_jump_dst (20), updated in COMPUTE with instr_pc and the target; both reset to 0.
  - $display of src, dst and push on each jump.
- When undefined: no ports and no displays; functional behaviour is identical.

Test Plan:
- GOTO (len=2), instr_pc=0x00100, nibbles 3,2,1 -> o_new_pc=0x00224, o_push_en=0, one o_load_pc pulse.
- Relative wrap: instr_pc=0xFFFFE, len=2, nibbles 5,0,0 -> o_new_pc=0x00004. Negative offset: instr_pc=0x00010, nibbles F,F,F -> o_new_pc=0x00010.
- GOSBVL (len=4, push=1), instr_pc=0x00200, nibbles 0,0,0,F,0 -> o_new_pc=0x0F000, o_push_addr=0x00207, o_push_en and o_load_pc in the same cycle.
- GOVLNG with i_bus_busy high for 3 phase-2 cycles mid-operand, nibbles 5,4,3,2,1 -> stalled nibbles are not captured, o_new_pc=0x12345, pulse delayed by exactly the stall.
- i_reset during COLLECT after 2 nibbles -> IDLE, o_jump_busy=0, no pulse; a following GOTO computes correctly.
- Execute strobe with len=5 -> o_error=1 sticky, no pulse, o_jump_busy=0; execute held high after a jump -> no second o_load_pc.

Source files
------------

// File: rtl/saturn_jump_unit.sv
// saturn_jump_unit
//
// Executes jump-class instructions (GOTO, GOSUB, GOVLNG, GOSBVL and the
// short relative jumps) handed over by the instruction decoder. The operand
// nibbles are collected least-significant first from the phase-sequenced
// fetch stream. A 20-bit target is then computed, either absolute or
// relative to the instruction address. Finally one-shot PC-load and
// return-stack-push requests are issued to the PC/RSTK logic.
//
// Ports:
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_clk_en              global enable; nothing changes while low
//   i_phases[3:0]         one-hot nibble phase; nibbles are taken in phase 2
//   i_bus_busy            bus owns the cycle, suppresses nibble capture
//   i_nibble[3:0]         current fetched nibble
//   i_instr_type[3:0]     decoder instruction type
//   i_instr_execute       decoder execute strobe
//   i_jump_length[2:0]    operand nibbles minus one (1..4 legal, 4 = absolute)
//   i_push_pc             push the return address (GOSUB-style jumps)
//   i_instr_pc[19:0]      address of the first opcode nibble
//   o_load_pc / o_new_pc  one-cycle PC-load request and target
//   o_push_en / o_push_addr  one-cycle return-stack push and return address
//   o_jump_busy           high whenever the unit is not idle
//   o_jump_done           completion pulse, coincident with o_load_pc
//   o_error               sticky illegal-length flag
//
// Optional build macro SATURN_JUMP_TRACE_EN adds o_dbg_jump_src/o_dbg_jump_dst
// and a simulation trace line per jump.

`ifndef INSTR_TYPE_JUMP
`define INSTR_TYPE_JUMP 4'h3
`endif

module saturn_jump_unit #(
    parameter int REL_PREFIX = 1,
    parameter int ABS_PREFIX = 2
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_clk_en,
    input  logic [3:0]  i_phases,
    input  logic        i_bus_busy,
    input  logic [3:0]  i_nibble,
    input  logic [3:0]  i_instr_type,
    input  logic        i_instr_execute,
    input  logic [2:0]  i_jump_length,
    input  logic        i_push_pc,
    input  logic [19:0] i_instr_pc,
    output logic        o_load_pc,
    output logic [19:0] o_new_pc,
    output logic        o_push_en,
    output logic [19:0] o_push_addr,
    output logic        o_jump_busy,
    output logic        o_jump_done,
`ifdef SATURN_JUMP_TRACE_EN
    output logic [19:0] o_dbg_jump_src,
    output logic [19:0] o_dbg_jump_dst,
`endif
    output logic        o_error
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_COMPUTE,
        S_RELEASE
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  len_q, len_d;
    logic        push_q, push_d;
    logic [19:0] pc_q, pc_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [19:0] acc_q, acc_d;
    logic        load_q, load_d;
    logic [19:0] new_pc_q, new_pc_d;
    logic        push_en_q, push_en_d;
    logic [19:0] push_addr_q, push_addr_d;
    logic        error_q, error_d;

    logic        jump_strobe;
    logic        len_legal;
    logic [19:0] offset_sext;
    logic [19:0] target;
    logic [19:0] ret_addr;

    // Only phase 2 is used for capture; the other phase bits are ignored.
    logic unused_phases;
    assign unused_phases = ^{i_phases[3], i_phases[1:0]};

    assign jump_strobe = i_instr_execute && (i_instr_type == `INSTR_TYPE_JUMP);
    assign len_legal   = (i_jump_length >= 3'd1) && (i_jump_length <= 3'd4);

    // Relative offsets are two's complement over len+1 nibbles.
    always_comb begin
        offset_sext = acc_q;
        case (len_q)
            3'd1:    offset_sext = {{12{acc_q[7]}},  acc_q[7:0]};
            3'd2:    offset_sext = {{8{acc_q[11]}},  acc_q[11:0]};
            3'd3:    offset_sext = {{4{acc_q[15]}},  acc_q[15:0]};
            default: offset_sext = acc_q;
        endcase
    end

    // Both sums wrap modulo 2^20 by truncation.
    assign target = (len_q == 3'd4) ? acc_q
                                    : pc_q + 20'(REL_PREFIX) + offset_sext;
    assign ret_addr = pc_q
                    + ((len_q == 3'd4) ? 20'(ABS_PREFIX) : 20'(REL_PREFIX))
                    + 20'(len_q) + 20'd1;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        push_d      = push_q;
        pc_d        = pc_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        load_d      = 1'b0;
        new_pc_d    = new_pc_q;
        push_en_d   = 1'b0;
        push_addr_d = push_addr_q;
        error_d     = error_q;

        case (state_q)
            S_IDLE: begin
                if (jump_strobe) begin
                    if (len_legal) begin
                        len_d   = i_jump_length;
                        push_d  = i_push_pc;
                        pc_d    = i_instr_pc;
                        cnt_d   = 3'd0;
                        acc_d   = 20'd0;
                        state_d = S_COLLECT;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            S_COLLECT: begin
                if (i_phases[2] && !i_bus_busy) begin
                    for (int i = 0; i < 5; i++) begin
                        if (cnt_q == 3'(i)) begin
                            acc_d[4*i +: 4] = i_nibble;
                        end
                    end
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == len_q) begin
                        state_d = S_COMPUTE;
                    end
                end
            end
            S_COMPUTE: begin
                load_d   = 1'b1;
                new_pc_d = target;
                if (push_q) begin
                    push_en_d   = 1'b1;
                    push_addr_d = ret_addr;
                end
                state_d = S_RELEASE;
            end
            S_RELEASE: begin
                // Hold off until the decoder drops its strobe so the same
                // execute pulse cannot launch a second jump.
                if (!i_instr_execute) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= S_IDLE;
            len_q       <= 3'd0;
            push_q      <= 1'b0;
            pc_q        <= 20'd0;
            cnt_q       <= 3'd0;
            acc_q       <= 20'd0;
            load_q      <= 1'b0;
            new_pc_q    <= 20'd0;
            push_en_q   <= 1'b0;
            push_addr_q <= 20'd0;
            error_q     <= 1'b0;
        end else if (i_clk_en) begin
            state_q     <= state_d;
            len_q       <= len_d;
            push_q      <= push_d;
            pc_q        <= pc_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            load_q      <= load_d;
            new_pc_q    <= new_pc_d;
            push_en_q   <= push_en_d;
            push_addr_q <= push_addr_d;
            error_q     <= error_d;
        end
    end

    assign o_load_pc   = load_q;
    assign o_jump_done = load_q;
    assign o_new_pc    = new_pc_q;
    assign o_push_en   = push_en_q;
    assign o_push_addr = push_addr_q;
    assign o_jump_busy = (state_q != S_IDLE);
    assign o_error     = error_q;

`ifdef SATURN_JUMP_TRACE_EN
    logic [19:0] dbg_src_q, dbg_src_d;
    logic [19:0] dbg_dst_q, dbg_dst_d;

    always_comb begin
        dbg_src_d = dbg_src_q;
        dbg_dst_d = dbg_dst_q;
        if (state_q == S_COMPUTE) begin
            dbg_src_d = pc_q;
            dbg_dst_d = target;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            dbg_src_q <= 20'd0;
            dbg_dst_q <= 20'd0;
        end else if (i_clk_en) begin
            dbg_src_q <= dbg_src_d;
            dbg_dst_q <= dbg_dst_d;
            if (state_q == S_COMPUTE) begin
                $display("saturn_jump_unit: jump src=%05h dst=%05h push=%0b",
                         pc_q, target, push_q);
            end
        end
    end

    assign o_dbg_jump_src = dbg_src_q;
    assign o_dbg_jump_dst = dbg_dst_q;
`endif

endmodule
